// File: rtl/cacheline_arbiter_if.sv
// Cache-side and physical-memory-side signals of the cache line arbiter.
// slave is the arbiter itself; master is everything around it (caches and memory).
interface cacheline_arbiter_if #(
    parameter int BURST_LEN = 4
);
    localparam int LINE_W = BURST_LEN * 64;

    logic              i_read;
    logic [31:0]       i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [31:0]       d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [63:0]       pmem_wdata;
    logic [63:0]       pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cacheline_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one 64-bit burst memory port.
// CACHELINE_ARB_RR_EN selects round-robin tie-breaking; otherwise the D-cache wins ties.
//
// state | meaning
// IDLE  | waiting for a request, arbitration happens here
// I_RD  | read burst for the I-cache
// D_RD  | read burst for the D-cache
// D_WR  | write-back burst for the D-cache
// DONE  | one-cycle response pulse to the owner
module cacheline_arbiter #(
    parameter int BURST_LEN = 4
) (
    input logic clk,
    input logic rst,
    cacheline_arbiter_if.slave bus
);
    localparam int LINE_W = BURST_LEN * 64;
    localparam int BW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

    state_t            state;
    logic [BW-1:0]     beat;
    logic [BW-1:0]     beat_inc;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] line_next;
    logic [63:0]       wdata_next;
    logic              owner_d;
    logic              i_req;
    logic              d_req;
    logic              grant_d;
    logic              grant_i;
    logic              last_beat;
    logic [31:0]       grant_addr;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

`ifdef CACHELINE_ARB_RR_EN
    // Set when the I-cache should win the next tie.
    logic prio_i;
    assign grant_d = d_req & (~i_req | ~prio_i);
`else
    assign grant_d = d_req;
`endif
    assign grant_i    = i_req & ~grant_d;
    assign grant_addr = grant_d ? bus.d_address : bus.i_address;

    assign last_beat = (beat == BW'(BURST_LEN - 1));
    assign beat_inc  = beat + 1'b1;

    always_comb begin
        line_next = line_buf;
        line_next[int'(beat) * 64 +: 64] = bus.pmem_rdata;
        wdata_next = line_buf[int'(beat_inc) * 64 +: 64];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            beat             <= '0;
            line_buf         <= '0;
            owner_d          <= 1'b0;
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata   <= '0;
            bus.i_rdata      <= '0;
            bus.d_rdata      <= '0;
            bus.i_resp       <= 1'b0;
            bus.d_resp       <= 1'b0;
`ifdef CACHELINE_ARB_RR_EN
            prio_i           <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d | grant_i) begin
                        bus.pmem_address <= {grant_addr[31:5], 5'b0};
                        owner_d          <= grant_d;
                        beat             <= '0;
`ifdef CACHELINE_ARB_RR_EN
                        prio_i           <= grant_d;
`endif
                        // A simultaneous read and write from the D-cache is a write-back.
                        if (grant_d && bus.d_write) begin
                            state          <= D_WR;
                            bus.pmem_write <= 1'b1;
                            line_buf       <= bus.d_wdata;
                            bus.pmem_wdata <= bus.d_wdata[63:0];
                        end else begin
                            state         <= grant_d ? D_RD : I_RD;
                            bus.pmem_read <= 1'b1;
                        end
                    end
                end
                I_RD, D_RD: begin
                    if (bus.pmem_resp) begin
                        line_buf <= line_next;
                        if (last_beat) begin
                            beat          <= '0;
                            state         <= DONE;
                            bus.pmem_read <= 1'b0;
                            if (owner_d) begin
                                bus.d_rdata <= line_next;
                                bus.d_resp  <= 1'b1;
                            end else begin
                                bus.i_rdata <= line_next;
                                bus.i_resp  <= 1'b1;
                            end
                        end else begin
                            beat <= beat_inc;
                        end
                    end
                end
                D_WR: begin
                    if (bus.pmem_resp) begin
                        if (last_beat) begin
                            beat           <= '0;
                            state          <= DONE;
                            bus.pmem_write <= 1'b0;
                            bus.d_resp     <= 1'b1;
                        end else begin
                            beat           <= beat_inc;
                            bus.pmem_wdata <= wdata_next;
                        end
                    end
                end
                DONE: begin
                    bus.i_resp <= 1'b0;
                    bus.d_resp <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter; expectations follow CACHELINE_ARB_RR_EN when defined.
module tb_cacheline_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cacheline_arbiter_if #(.BURST_LEN(4)) bus ();
    cacheline_arbiter #(.BURST_LEN(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // owner codes: 0 = I read, 1 = D read, 2 = D write
    int           owner_q[$];
    logic [255:0] exp_i_q[$];
    logic [255:0] exp_d_q[$];
    logic [63:0]  exp_w_q[$];

    logic [63:0] rd_beats [4];
    int  bi = 0;
    bit  pend = 0;
    bit  phase = 0;
    bit  every_other = 0;
    bit  idle_resp = 0;
    int  i_resp_cnt = 0;
    int  d_resp_cnt = 0;
    bit  saw_read = 0;
    bit  saw_strobe = 0;
    bit  saw_both = 0;

    function automatic logic [255:0] cur_line();
        return {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]};
    endfunction

    // Memory model: answers beats from rd_beats and checks write beats.
    initial begin
        bit strobe;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pend) bi = (bi + 1) % 4;
            pend   = 0;
            phase  = ~phase;
            strobe = bus.pmem_read | bus.pmem_write;
            if (bus.pmem_write && exp_w_q.size() > 0)
                chk("wdata_hold", bus.pmem_wdata, exp_w_q[0]);
            if (strobe && (!every_other || phase)) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = rd_beats[bi];
                pend = 1;
                if (bus.pmem_write) begin
                    if (exp_w_q.size() == 0) chk("wdata_extra_beat", 256'(exp_w_q.size()), 1);
                    else chk("pmem_wdata", bus.pmem_wdata, exp_w_q.pop_front());
                end
            end else if (!strobe && idle_resp) begin
                bus.pmem_resp  = phase;
                bus.pmem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
            end else begin
                bus.pmem_resp = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every response pulse.
    initial begin
        int code;
        forever begin
            @(negedge clk);
            if (bus.pmem_read) saw_read = 1;
            if (bus.pmem_read | bus.pmem_write) saw_strobe = 1;
            if (bus.pmem_read & bus.pmem_write) saw_both = 1;
            if (bus.i_resp) begin
                i_resp_cnt++;
                if (owner_q.size() == 0) chk("i_resp_unexpected", 256'(owner_q.size()), 1);
                else begin
                    code = owner_q.pop_front();
                    chk("i_resp_owner", 0, 256'(code));
                    if (exp_i_q.size() > 0) chk("i_rdata", bus.i_rdata, exp_i_q.pop_front());
                end
            end
            if (bus.d_resp) begin
                d_resp_cnt++;
                if (owner_q.size() == 0) chk("d_resp_unexpected", 256'(owner_q.size()), 1);
                else begin
                    code = owner_q.pop_front();
                    chk("d_resp_owner", 1, 256'(code != 0));
                    if (code == 1 && exp_d_q.size() > 0) chk("d_rdata", bus.d_rdata, exp_d_q.pop_front());
                end
            end
        end
    end

    // Runs until n responses arrive, dropping each request after its response.
    task automatic serve(input int n, output int first_cyc);
        int cnt = 0;
        first_cyc = -1;
        for (int c = 1; c <= 80 && cnt < n; c++) begin
            @(negedge clk);
            if (bus.i_resp) begin
                bus.i_read = 1'b0;
                cnt++;
                if (first_cyc < 0) first_cyc = c;
            end
            if (bus.d_resp) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
                cnt++;
                if (first_cyc < 0) first_cyc = c;
            end
        end
        if (cnt < n) chk("resp_timeout", 256'(cnt), 256'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bi = 0; pend = 0;
    endtask

    task automatic push_write(input logic [255:0] line);
        for (int k = 0; k < 4; k++) exp_w_q.push_back(line[k*64 +: 64]);
    endtask

    initial begin
        int lat;
        int cnt0;
        logic [255:0] wline;
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
        rd_beats[0] = {16{4'h1}}; rd_beats[1] = {16{4'h2}};
        rd_beats[2] = {16{4'h3}}; rd_beats[3] = {16{4'h4}};

        repeat (3) @(negedge clk);
        chk("rst_pmem_read", bus.pmem_read, 0);
        chk("rst_pmem_write", bus.pmem_write, 0);
        chk("rst_i_resp", bus.i_resp, 0);
        chk("rst_d_resp", bus.d_resp, 0);
        chk("rst_pmem_address", bus.pmem_address, 0);
        chk("rst_pmem_wdata", bus.pmem_wdata, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        rst = 1'b0;

        // I-read only
        @(negedge clk);
        exp_i_q.push_back(cur_line()); owner_q.push_back(0);
        bus.i_read = 1'b1; bus.i_address = 32'h0000_1234;
        cnt0 = i_resp_cnt;
        @(negedge clk);
        chk("i_pmem_address", bus.pmem_address, 32'h0000_1220);
        chk("i_pmem_read", bus.pmem_read, 1);
        serve(1, lat);
        chk("i_latency", 256'(lat + 1), 5);
        repeat (3) @(negedge clk);
        chk("i_resp_once", 256'(i_resp_cnt - cnt0), 1);
        chk("i_rdata_held", bus.i_rdata, {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});

        // D-write with pmem_resp every other cycle
        every_other = 1;
        wline = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        push_write(wline); owner_q.push_back(2);
        saw_read = 0; cnt0 = d_resp_cnt;
        bus.d_write = 1'b1; bus.d_address = 32'h8000_0040; bus.d_wdata = wline;
        @(negedge clk);
        chk("w_pmem_address", bus.pmem_address, 32'h8000_0040);
        chk("w_pmem_write", bus.pmem_write, 1);
        serve(1, lat);
        repeat (3) @(negedge clk);
        chk("w_d_resp_once", 256'(d_resp_cnt - cnt0), 1);
        chk("w_no_pmem_read", saw_read, 0);
        chk("w_beats_left", 256'(exp_w_q.size()), 0);
        every_other = 0;

        // Tie after reset, then a lone I-read, then a second tie
        do_reset();
        rd_beats[0] = 64'h0123_4567_89AB_CDEF; rd_beats[1] = 64'h1000_0000_0000_0001;
        rd_beats[2] = 64'h2000_0000_0000_0002; rd_beats[3] = 64'h3000_0000_0000_0003;
        exp_i_q.push_back(cur_line()); exp_d_q.push_back(cur_line());
`ifdef CACHELINE_ARB_RR_EN
        owner_q.push_back(0); owner_q.push_back(1);
`else
        owner_q.push_back(1); owner_q.push_back(0);
`endif
        bus.i_read = 1'b1; bus.i_address = 32'h0000_2000;
        bus.d_read = 1'b1; bus.d_address = 32'h0000_4000;
        serve(2, lat);
        chk("tie1_drained", 256'(owner_q.size()), 0);

        @(negedge clk);
        exp_i_q.push_back(cur_line()); owner_q.push_back(0);
        bus.i_read = 1'b1;
        serve(1, lat);
        @(negedge clk);
        exp_i_q.push_back(cur_line()); exp_d_q.push_back(cur_line());
        owner_q.push_back(1); owner_q.push_back(0);
        bus.i_read = 1'b1; bus.d_read = 1'b1;
        serve(2, lat);
        chk("tie2_drained", 256'(owner_q.size()), 0);

        // d_read and d_write together
        @(negedge clk);
        wline = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
        push_write(wline); owner_q.push_back(2);
        saw_read = 0;
        bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 32'h0000_0FFF; bus.d_wdata = wline;
        @(negedge clk);
        chk("rw_pmem_write", bus.pmem_write, 1);
        chk("rw_pmem_address", bus.pmem_address, 32'h0000_0FE0);
        serve(1, lat);
        chk("rw_no_pmem_read", saw_read, 0);
        chk("rw_beats_left", 256'(exp_w_q.size()), 0);

        // Reset after two beats of an I-read
        @(negedge clk);
        exp_i_q.push_back(cur_line()); owner_q.push_back(0);
        bus.i_read = 1'b1; bus.i_address = 32'h0000_3000;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_pmem_read", bus.pmem_read, 0);
        chk("rst_mid_i_resp", bus.i_resp, 0);
        bus.i_read = 1'b0;
        exp_i_q.delete(); owner_q.delete();
        bi = 0; pend = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_beats[0] = 64'hA5A5_0000_0000_0000; rd_beats[1] = 64'h5A5A_1111_1111_1111;
        rd_beats[2] = 64'hF0F0_2222_2222_2222; rd_beats[3] = 64'h0F0F_3333_3333_3333;
        @(negedge clk);
        exp_i_q.push_back(cur_line()); owner_q.push_back(0);
        bus.i_read = 1'b1;
        serve(1, lat);
        chk("rst_recover_latency", 256'(lat), 5);

        // pmem_resp toggling while idle
        repeat (2) @(negedge clk);
        cnt0 = i_resp_cnt + d_resp_cnt;
        saw_strobe = 0;
        idle_resp = 1;
        repeat (8) @(negedge clk);
        idle_resp = 0;
        @(negedge clk);
        chk("idle_no_resp", 256'(i_resp_cnt + d_resp_cnt - cnt0), 0);
        chk("idle_no_strobe", saw_strobe, 0);
        rd_beats[0] = 64'h0000_0000_0000_00B0; rd_beats[1] = 64'h0000_0000_0000_00B1;
        rd_beats[2] = 64'h0000_0000_0000_00B2; rd_beats[3] = 64'h0000_0000_0000_00B3;
        exp_i_q.push_back(cur_line()); owner_q.push_back(0);
        bus.i_read = 1'b1;
        serve(1, lat);
        repeat (2) @(negedge clk);

        chk("strobes_exclusive", saw_both, 0);
        chk("scoreboard_empty", 256'(owner_q.size() + exp_i_q.size() + exp_d_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
